// File: rtl/regfile_write_arbiter_if.sv
// Handshake bundle between the writeback/multdiv/decode side and the
// regfile write arbiter.
interface regfile_write_arbiter_if #(
    parameter int AW = 2
);
    logic          alu_valid;
    logic [4:0]    alu_rd;
    logic [31:0]   alu_data;
    logic          md_valid;
    logic [4:0]    md_rd;
    logic [31:0]   md_data;
    logic          md_ready;
    logic [4:0]    query_rd_a;
    logic [4:0]    query_rd_b;
    logic          query_pending_a;
    logic          query_pending_b;
    logic          ctrl_writeEnable;
    logic [4:0]    ctrl_writeReg;
    logic [31:0]   data_writeReg;
    logic [AW:0]   fifo_count;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output md_valid, md_rd, md_data,
        output query_rd_a, query_rd_b,
        input  md_ready, query_pending_a, query_pending_b,
        input  ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        input  fifo_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  md_valid, md_rd, md_data,
        input  query_rd_a, query_rd_b,
        output md_ready, query_pending_a, query_pending_b,
        output ctrl_writeEnable, ctrl_writeReg, data_writeReg,
        output fifo_count
    );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Sole regfile writer: ALU writeback wins the port, multdiv results queue
// in a small FIFO, stale queued writes are squashed on a newer ALU write.
module regfile_write_arbiter #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input logic clock,
    input logic ctrl_reset_n,
    regfile_write_arbiter_if.slave bus
);
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } mdEntry_t;

    localparam logic [AW:0] Full = (AW+1)'(DEPTH);

    mdEntry_t          entryQ [DEPTH];
    logic [DEPTH-1:0]  liveQ;
    logic [AW-1:0]     headQ;
    logic [AW-1:0]     tailQ;
    logic [AW:0]       countQ;

    logic              weQ;
    logic [4:0]        regQ;
    logic [31:0]       dataQ;

    logic              aluWr;
    logic              drain;
    logic              enq;
    logic              deq;
    logic              selWe;
    logic [4:0]        selRd;
    logic [31:0]       selData;
    logic              pendA;
    logic              pendB;

    assign aluWr = bus.alu_valid && (bus.alu_rd != 5'd0);
    assign drain = !aluWr && (countQ != '0);
    // md_ready comes from the registered count only, so a full FIFO
    // never accepts even when the head leaves in the same cycle.
    assign enq   = bus.md_valid && bus.md_ready && (bus.md_rd != 5'd0);

    assign bus.md_ready         = (countQ != Full);
    assign bus.fifo_count       = countQ;
    assign bus.ctrl_writeEnable = weQ;
    assign bus.ctrl_writeReg    = regQ;
    assign bus.data_writeReg    = dataQ;
    assign bus.query_pending_a  = pendA;
    assign bus.query_pending_b  = pendB;

    always_comb begin
        selWe   = 1'b0;
        selRd   = 5'd0;
        selData = 32'd0;
        deq     = 1'b0;
        unique case (1'b1)
            aluWr: begin
                selWe   = 1'b1;
                selRd   = bus.alu_rd;
                selData = bus.alu_data;
            end
            drain: begin
                deq = 1'b1;
                if (liveQ[headQ]) begin
                    selWe   = 1'b1;
                    selRd   = entryQ[headQ].rd;
                    selData = entryQ[headQ].data;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        pendA = weQ && (regQ == bus.query_rd_a);
        pendB = weQ && (regQ == bus.query_rd_b);
        for (int i = 0; i < DEPTH; i++) begin
            if (liveQ[i] && (entryQ[i].rd == bus.query_rd_a))
                pendA = 1'b1;
            if (liveQ[i] && (entryQ[i].rd == bus.query_rd_b))
                pendB = 1'b1;
        end
        if (bus.query_rd_a == 5'd0)
            pendA = 1'b0;
        if (bus.query_rd_b == 5'd0)
            pendB = 1'b0;
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            headQ  <= '0;
            tailQ  <= '0;
            countQ <= '0;
            liveQ  <= '0;
            weQ    <= 1'b0;
            regQ   <= 5'd0;
            dataQ  <= 32'd0;
            for (int i = 0; i < DEPTH; i++)
                entryQ[i] <= '0;
        end else begin
            weQ   <= selWe;
            regQ  <= selRd;
            dataQ <= selData;
            // Squash hits only entries already queued; the tail write
            // below comes later and so wins for a same-edge enqueue.
            if (aluWr) begin
                for (int i = 0; i < DEPTH; i++)
                    if (entryQ[i].rd == bus.alu_rd)
                        liveQ[i] <= 1'b0;
            end
            if (deq) begin
                liveQ[headQ] <= 1'b0;
                headQ        <= headQ + AW'(1);
            end
            if (enq) begin
                entryQ[tailQ] <= '{rd: bus.md_rd, data: bus.md_data};
                liveQ[tailQ]  <= 1'b1;
                tailQ         <= tailQ + AW'(1);
            end
            countQ <= countQ + (AW+1)'(enq) - (AW+1)'(deq);
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter against a
// queue-based reference model.
module tb_regfile_write_arbiter;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          live;
    } ent_t;

    logic clock = 1'b0;
    logic ctrl_reset_n = 1'b0;

    regfile_write_arbiter_if #(.AW(AW)) bus ();

    regfile_write_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .bus          (bus.slave)
    );

    always #5 clock = ~clock;

    ent_t        mq[$];
    bit          outWe;
    logic [4:0]  outRd;
    logic [31:0] outData;
    bit          lastAcc;
    int          nChecks = 0;
    int          nFails  = 0;

    task automatic checkEq(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic bit pend(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        if (outWe && outRd == q) return 1'b1;
        foreach (mq[i])
            if (mq[i].live && mq[i].rd == q) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step(input bit av, input logic [4:0] ar,
                        input logic [31:0] ad, input bit mv,
                        input logic [4:0] mr, input logic [31:0] md,
                        input logic [4:0] qa, input logic [4:0] qb);
        bit          nWe;
        logic [4:0]  nRd;
        logic [31:0] nData;
        ent_t        e;
        @(negedge clock);
        bus.alu_valid  = av;
        bus.alu_rd     = ar;
        bus.alu_data   = ad;
        bus.md_valid   = mv;
        bus.md_rd      = mr;
        bus.md_data    = md;
        bus.query_rd_a = qa;
        bus.query_rd_b = qb;
        #1;
        checkEq("md_ready", 32'(bus.md_ready), 32'(mq.size() != DEPTH));
        checkEq("fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
        checkEq("pending_a", 32'(bus.query_pending_a), 32'(pend(qa)));
        checkEq("pending_b", 32'(bus.query_pending_b), 32'(pend(qb)));
        lastAcc = mv && (mq.size() != DEPTH);
        nWe = 1'b0; nRd = 5'd0; nData = 32'd0;
        if (av && ar != 5'd0) begin
            foreach (mq[i])
                if (mq[i].rd == ar) mq[i].live = 1'b0;
            nWe = 1'b1; nRd = ar; nData = ad;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            if (e.live) begin
                nWe = 1'b1; nRd = e.rd; nData = e.data;
            end
        end
        if (lastAcc && mr != 5'd0)
            mq.push_back('{rd: mr, data: md, live: 1'b1});
        @(posedge clock);
        #1;
        outWe = nWe; outRd = nRd; outData = nData;
        checkEq("writeEnable", 32'(bus.ctrl_writeEnable), 32'(outWe));
        checkEq("writeReg", 32'(bus.ctrl_writeReg), 32'(outRd));
        checkEq("writeData", bus.data_writeReg, outData);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++)
            step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_data = 0;
        bus.md_valid = 0; bus.md_rd = 0; bus.md_data = 0;
        bus.query_rd_a = 0; bus.query_rd_b = 0;
        outWe = 0; outRd = 0; outData = 0; lastAcc = 0;
        repeat (3) @(posedge clock);
        #1;
        checkEq("rst_we", 32'(bus.ctrl_writeEnable), 0);
        checkEq("rst_count", 32'(bus.fifo_count), 0);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        #1;
        checkEq("rst_ready", 32'(bus.md_ready), 1);

        // Mid-stream reset with three queued entries
        for (int i = 1; i <= 3; i++)
            step(1, 5'd20, 32'(i), 1, 5'(10 + i), 32'(i), 0, 0);
        checkEq("t1_count3", 32'(bus.fifo_count), 3);
        @(negedge clock);
        bus.alu_valid = 0; bus.md_valid = 0;
        ctrl_reset_n = 1'b0;
        #1;
        checkEq("t1_we", 32'(bus.ctrl_writeEnable), 0);
        checkEq("t1_count", 32'(bus.fifo_count), 0);
        mq.delete();
        outWe = 0; outRd = 0; outData = 0;
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        #1;
        checkEq("t1_ready", 32'(bus.md_ready), 1);

        // Single ALU write then silence
        step(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 5, 0);
        checkEq("t2_we", 32'(bus.ctrl_writeEnable), 1);
        checkEq("t2_reg", 32'(bus.ctrl_writeReg), 5);
        checkEq("t2_data", bus.data_writeReg, 32'hDEADBEEF);
        step(0, 0, 0, 0, 0, 0, 5, 0);
        checkEq("t2_we0", 32'(bus.ctrl_writeEnable), 0);
        checkEq("t2_data0", bus.data_writeReg, 0);

        // md waits behind three ALU writes
        step(1, 5'd3, 32'h1, 1, 5'd7, 32'h11, 7, 3);
        checkEq("t3_cnt_a", 32'(bus.fifo_count), 1);
        step(1, 5'd3, 32'h2, 0, 0, 0, 7, 3);
        checkEq("t3_cnt_b", 32'(bus.fifo_count), 1);
        step(1, 5'd3, 32'h3, 0, 0, 0, 7, 3);
        checkEq("t3_cnt_c", 32'(bus.fifo_count), 1);
        step(0, 0, 0, 0, 0, 0, 7, 3);
        checkEq("t3_reg", 32'(bus.ctrl_writeReg), 7);
        checkEq("t3_data", bus.data_writeReg, 32'h11);
        idle(2);

        // Fill to full behind a busy ALU, then drain in order
        for (int i = 1; i <= 4; i++)
            step(1, 5'd20, 32'(i), 1, 5'(i), 32'(100 + i), 1, 4);
        step(1, 5'd20, 32'h9, 1, 5'd6, 32'h106, 6, 2);
        checkEq("t4_held", 32'(lastAcc), 0);
        checkEq("t4_cnt", 32'(bus.fifo_count), 4);
        step(0, 0, 0, 1, 5'd6, 32'h106, 6, 1);
        checkEq("t4_first", 32'(bus.ctrl_writeReg), 1);
        for (int k = 0; k < 8 && !lastAcc; k++)
            step(0, 0, 0, 1, 5'd6, 32'h106, 6, 3);
        checkEq("t4_accept5", 32'(lastAcc), 1);
        idle(6);

        // WAW squash of a queued write
        step(1, 5'd3, 32'h0, 1, 5'd9, 32'hAA, 9, 0);
        step(1, 5'd9, 32'hBB, 0, 0, 0, 9, 0);
        checkEq("t5_data", bus.data_writeReg, 32'hBB);
        step(0, 0, 0, 0, 0, 0, 9, 0);
        checkEq("t5_nowrite", 32'(bus.ctrl_writeEnable), 0);
        step(0, 0, 0, 0, 0, 0, 9, 9);
        checkEq("t5_pend9", 32'(bus.query_pending_a), 0);

        // Register zero requests are dropped
        for (int k = 0; k < 4; k++) begin
            step(1, 0, 32'h5, 1, 0, 32'h6, 0, 0);
            checkEq("t6_we", 32'(bus.ctrl_writeEnable), 0);
            checkEq("t6_cnt", 32'(bus.fifo_count), 0);
        end
        checkEq("t6_pend0", 32'(bus.query_pending_a), 0);

        // Random traffic with deliberate register collisions
        for (int c = 0; c < 3000; c++)
            step($urandom_range(0, 99) < 40, 5'($urandom_range(0, 7)),
                 $urandom, $urandom_range(0, 99) < 60,
                 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nChecks, nFails);
        $finish;
    end
endmodule
